// File: rtl/uart_core_param.sv
// Parametrised UART core: configurable data/parity/stop/baud, 16x oversampled RX with
// glitch rejection, RX FIFO with ready/valid pop, sticky error flags and a registered irq.
module uart_core_param #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       irq
);
    localparam int DIV      = CLK_HZ / (BAUD * 16);
    localparam int BIT_CLKS = 16 * DIV;
    localparam int DCW      = $clog2(DIV);
    localparam int BCW      = $clog2(BIT_CLKS);
    localparam int AW       = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    // Upper tx_byte bits are ignored for narrow data widths.
    logic unused_s;
    assign unused_s = ^tx_byte;

    logic [DCW-1:0] div_cnt_q, div_cnt_d;
    logic           tick_s;
    logic           rx_meta_q, rx_s_q;

    // Free-running oversampling tick generator
    always_comb begin
        tick_s    = (div_cnt_q == DCW'(DIV - 1));
        div_cnt_d = tick_s ? '0 : div_cnt_q + DCW'(1);
    end

    // Tick counter and two-flop rx synchroniser
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ---------------- transmitter ----------------
    state_e               tx_state_q, tx_state_d;
    logic [BCW-1:0]       tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 tx_end_s;

    // TX next-state: the data register shifts right so the next bit is always at [1]
    always_comb begin
        tx_state_d = tx_state_q;
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        tx_end_s   = (tx_cnt_q == BCW'(BIT_CLKS - 1));
        tx_cnt_d   = tx_end_s ? '0 : tx_cnt_q + BCW'(1);
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (transmit) begin
                    tx_data_d  = tx_byte[DATA_BITS-1:0];
                    tx_par_d   = (PARITY == 32'sd1) ? ~^tx_byte[DATA_BITS-1:0] : ^tx_byte[DATA_BITS-1:0];
                    tx_state_d = S_START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            S_START: begin
                if (tx_end_s) begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_data_q[0];
                end else begin
                    tx_d = 1'b0;
                end
            end
            S_DATA: begin
                if (tx_end_s && (tx_bit_q == 3'(DATA_BITS - 1))) begin
                    tx_bit_d = 3'd0;
                    if (PARITY != 32'sd0) begin
                        tx_state_d = S_PARITY;
                        tx_d       = tx_par_q;
                    end else begin
                        tx_state_d = S_STOP;
                        tx_d       = 1'b1;
                    end
                end else if (tx_end_s) begin
                    tx_bit_d  = tx_bit_q + 3'd1;
                    tx_data_d = tx_data_q >> 1;
                    tx_d      = tx_data_q[1];
                end else begin
                    tx_d = tx_data_q[0];
                end
            end
            S_PARITY: begin
                if (tx_end_s) begin
                    tx_state_d = S_STOP;
                    tx_bit_d   = 3'd0;
                    tx_d       = 1'b1;
                end else begin
                    tx_d = tx_par_q;
                end
            end
            S_STOP: begin
                if (tx_end_s && (tx_bit_q == 3'(STOP_BITS - 1))) begin
                    tx_state_d = S_IDLE;
                    busy_d     = 1'b0;
                end else if (tx_end_s) begin
                    tx_bit_d = tx_bit_q + 3'd1;
                end else begin
                    tx_d = 1'b1;
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // TX state and registered line/busy outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_data_q  <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_data_q  <= tx_data_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    // ---------------- receiver ----------------
    state_e               rx_state_q, rx_state_d;
    logic [3:0]           rx_tcnt_q, rx_tcnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 mid_s, half_s, push_s, pe_set_s, fe_set_s, par_exp_s;

    // RX next-state: START waits 8 ticks, every later bit is sampled 16 ticks apart
    always_comb begin
        rx_state_d = rx_state_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        push_s     = 1'b0;
        pe_set_s   = 1'b0;
        fe_set_s   = 1'b0;
        half_s     = tick_s && (rx_tcnt_q == 4'd7);
        mid_s      = tick_s && (rx_tcnt_q == 4'd15);
        par_exp_s  = (PARITY == 32'sd1) ? ~^rx_sh_q : ^rx_sh_q;
        rx_tcnt_d  = tick_s ? rx_tcnt_q + 4'd1 : rx_tcnt_q;
        case (rx_state_q)
            S_IDLE: begin
                rx_tcnt_d = 4'd0;
                if (!rx_s_q) begin
                    rx_state_d = S_START;
                end else begin
                    rx_state_d = S_IDLE;
                end
            end
            S_START: begin
                if (half_s) begin
                    rx_tcnt_d  = 4'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    rx_state_d = S_START;
                end
            end
            S_DATA: begin
                if (mid_s) begin
                    rx_sh_d = {rx_s_q, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_bit_q == 3'(DATA_BITS - 1)) begin
                        rx_bit_d   = 3'd0;
                        rx_state_d = (PARITY != 32'sd0) ? S_PARITY : S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (mid_s) begin
                    pe_set_s   = (rx_s_q != par_exp_s);
                    rx_bit_d   = 3'd0;
                    rx_state_d = S_STOP;
                end else begin
                    rx_state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (mid_s) begin
                    fe_set_s = ~rx_s_q;
                    if (rx_bit_q == 3'(STOP_BITS - 1)) begin
                        push_s     = 1'b1;
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_state_d = S_STOP;
                end
            end
            default: begin
                rx_state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- FIFO, flags, irq ----------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
    logic [7:0]           rx_byte_q, rx_byte_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 pe_q, pe_d, fe_q, fe_d, ov_q, ov_d, irq_q, irq_d;
    logic                 full_s, pop_s, push_ok_s, ov_set_s;
    logic [DATA_BITS-1:0] head_s;

    // Pointer update and next head; a push into an empty FIFO bypasses the memory
    always_comb begin
        full_s    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop_s     = rx_valid_q & rx_ready;
        push_ok_s = push_s && (!full_s || pop_s);
        ov_set_s  = push_s && full_s && !pop_s;
        wr_d      = push_ok_s ? wr_q + {{AW{1'b0}}, 1'b1} : wr_q;
        rd_d      = pop_s ? rd_q + {{AW{1'b0}}, 1'b1} : rd_q;
        if (wr_d == rd_d) begin
            head_s = '0;
        end else if (push_ok_s && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
            head_s = rx_sh_q;
        end else begin
            head_s = mem_q[rd_d[AW-1:0]];
        end
        rx_byte_d                 = 8'h00;
        rx_byte_d[DATA_BITS-1:0]  = head_s;
        rx_valid_d                = (wr_d != rd_d);
        pe_d  = pe_set_s ? 1'b1 : (err_clr ? 1'b0 : pe_q);
        fe_d  = fe_set_s ? 1'b1 : (err_clr ? 1'b0 : fe_q);
        ov_d  = ov_set_s ? 1'b1 : (err_clr ? 1'b0 : ov_q);
        irq_d = rx_valid_q | pe_q | fe_q | ov_q;
    end

    // RX FSM, FIFO storage and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= S_IDLE;
            rx_tcnt_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ov_q       <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            if (push_ok_s) mem_q[wr_q[AW-1:0]] <= rx_sh_q;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            ov_q       <= ov_d;
            irq_q      <= irq_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign rx_byte    = rx_byte_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign overrun    = ov_q;
    assign irq        = irq_q;
endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised next-generation UART core that succeeds the fixed 8N1 uart_rtl. It supports configurable data width, parity, stop bits and baud rate, with 16x-oversampled receive, glitch rejection and a receive FIFO. It keeps the legacy tx/rx/transmit/tx_byte/busy/rx_byte/irq interface and adds a ready/valid RX pop and sticky error flags. It sits between a host bus-side controller and the serial pads, and is exercised against the opencores 16550 model.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate; DIV = CLK_HZ/(BAUD*16), integer-truncated, must be >= 2
DATA_BITS, 8, data bits per frame, 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, RX FIFO entries, power of 2, >= 2

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  reset, asynchronous, active-low
rx  input  1  serial input, asynchronous to clk
tx  output  1  serial output, idles high
transmit  input  1  TX request, sampled when busy=0
tx_byte  input  8  TX data; only [DATA_BITS-1:0] is used
busy  output  1  TX frame in progress
rx_byte  output  8  FIFO head; bits at and above DATA_BITS are 0
rx_valid  output  1  FIFO not empty
rx_ready  input  1  pop the head when rx_valid=1
parity_err  output  1  sticky parity error
frame_err  output  1  sticky stop-bit error
overrun  output  1  sticky, a frame was dropped because the FIFO was full
err_clr  input  1  one-cycle pulse that clears all three sticky flags
irq  output  1  registered: rx_valid | parity_err | frame_err | overrun

Behaviour:
- Reset (rst=0, asynchronous): tx=1, busy=0, rx_byte=0, rx_valid=0, all flags 0, irq=0. Both FSMs go to IDLE and the FIFO is emptied. A reset mid-frame aborts the frame immediately and nothing is pushed.
- Tick generator: a free-running counter 0..DIV-1 emits a one-clock tick at DIV-1; it is used by RX only.
- TX FSM, states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE:
  - In IDLE, transmit=1 latches tx_byte. On the next cycle busy=1 and tx=0 (start bit).
  - Each bit lasts exactly 16*DIV clocks, timed by a private counter cleared at accept.
  - Data bits are sent LSB first. PARITY is skipped when PARITY=0. STOP drives 1 for STOP_BITS bit times.
  - busy falls the cycle after the last stop bit ends. A new frame can be accepted in that same cycle (back-to-back operation).
  - transmit while busy=1 is ignored.
- RX path: rx passes through a 2-flop synchroniser to rx_s.
- RX FSM, states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE:
  - In IDLE, rx_s=0 enters START. After 8 ticks rx_s is resampled: 0 goes to DATA, 1 returns to IDLE (glitch, no flags).
  - Every subsequent bit is sampled at 16-tick intervals (mid-bit), LSB first, into a DATA_BITS shift register.
  - A parity mismatch sets parity_err.
  - Every stop sample must be 1; a 0 sets frame_err.
  - At the last stop mid-sample the frame is pushed and the FSM returns to IDLE, ready for a start edge half a bit early.
  - Frames with parity or frame errors are still pushed.
- FIFO: pointers are log2(FIFO_DEPTH)+1 bits wide with wrap. Pop happens when rx_valid & rx_ready; rx_byte updates on the following cycle.
  - Push into a full FIFO drops the frame and sets overrun.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Push and pop in the same cycle while empty: not possible, because the pop needs rx_valid.
- Sticky flags: if err_clr and a new error set occur in the same cycle, set wins.
- irq: registered, so it lags its sources by 1 cycle.

Test Plan:
- Reset: hold rst=0 for 200 ns with rx=1 -> tx=1, busy=0, rx_valid=0, irq=0. Pulse rst low mid-TX frame -> tx=1 and busy=0 immediately.
- TX 8N1 with defaults (DIV=27, bit=432 clocks): transmit pulse with tx_byte=0x41 -> busy=1 next cycle. tx sequence 0,1,0,0,0,0,0,1,0,1, each bit held 432 clocks. busy=0 after 4320 clocks.
- Loopback tx->rx with PARITY=2, STOP_BITS=2: send 0x58 -> rx_valid=1, rx_byte=0x58, parity_err=0. Then inject a frame with inverted parity -> parity_err=1 and irq=1. err_clr -> parity_err=0.
- Overrun with FIFO_DEPTH=4 and rx_ready=0: send 'X','Y','Z','1','2' -> overrun=1 after the 5th frame. Pops return 0x58, 0x59, 0x5A, 0x31, then rx_valid=0.
- Glitch and frame error: rx low for 100 clocks (< 216) -> no push, no flags. Frame 0x43 with stop bit driven 0 -> rx_byte=0x43 pushed and frame_err=1.
- DATA_BITS=5 with PARITY=1: send 0x1F -> parity bit on tx=0, received rx_byte=0x1F with bits [7:5]=0.
